// File: rtl/ram_if_pkg.sv
// Shared types and helpers for the RAM initiator: FSM state encoding,
// default geometry constants and the strobe-to-bit-mask expansion.
// Purely declarative; no logic of its own.
package ram_if_pkg;

  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_HOLD_CYCLES  = 2;

  // Upper bound for the lane-mask helper; callers zero-extend their strobe
  // and cast the result back down to their own data width.
  localparam int MAX_STROBE_WIDTH = 64;
  localparam int MAX_DATA_WIDTH   = MAX_STROBE_WIDTH * 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Expand one enable bit per byte lane into a full-width data mask.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_mask(
    input logic [MAX_STROBE_WIDTH-1:0] strobe
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_STROBE_WIDTH; i++) begin
      mask[8*i +: 8] = {8{strobe[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ram_strobe_gen.sv
// Purpose: decode byte lane + byte count into RAM strobe, data mask and error flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated continuously from the command port.
// Ports: lane (address low bits), bytes (1/2/4/8) -> strobe, mask, err.
module ram_strobe_gen
  import ram_if_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  localparam int LANE_WIDTH  = $clog2(STROBE_WIDTH)
) (
  input  logic [LANE_WIDTH-1:0]   lane,
  input  logic [3:0]              bytes,
  output logic [STROBE_WIDTH-1:0] strobe,
  output logic [DATA_WIDTH-1:0]   mask,
  output logic                    err
);

  logic                    size_ok;
  logic                    fits;
  logic [STROBE_WIDTH-1:0] run;

  always_comb begin
    size_ok = (bytes == 4'd1) || (bytes == 4'd2) ||
              (bytes == 4'd4) || (bytes == 4'd8);
    fits    = (int'(lane) + int'(bytes)) <= STROBE_WIDTH;
    err     = !(size_ok && fits);
    // A full-width count shifts the one out entirely; the subtraction then
    // wraps to all ones, which is exactly the run we want.
    run     = (STROBE_WIDTH'(1) << bytes) - STROBE_WIDTH'(1);
    strobe  = err ? '0 : (run << lane);
    mask    = DATA_WIDTH'(lane_mask(MAX_STROBE_WIDTH'(strobe)));
  end

endmodule

// File: rtl/ram_initiator.sv
// Purpose: turn valid/ready read/write commands into timed accesses on a byte-strobed RAM.
// Latency: legal command -> response HOLD_CYCLES+1 cycles after accept; rejected command -> 1 cycle.
// Backpressure: one command in flight; cmd_ready low until the response is taken with rsp_ready.
// Ports: cmd_* command in, rsp_* response out, ram_* drive the RAM, ram_data_out is the RAM read data.
module ram_initiator
  import ram_if_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [3:0]              cmd_bytes,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    ram_cs,
  output logic                    ram_wr_enb,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [STROBE_WIDTH-1:0] ram_strobe,
  output logic [DATA_WIDTH-1:0]   ram_data_in,
  input  logic [DATA_WIDTH-1:0]   ram_data_out
);

  localparam int LANE_WIDTH = $clog2(STROBE_WIDTH);
  localparam int CNT_WIDTH  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(HOLD_CYCLES - 1);

  state_t                  state;
  state_t                  next_state;
  logic [CNT_WIDTH-1:0]    hold_cnt;
  logic [DATA_WIDTH-1:0]   mask_q;
  logic [STROBE_WIDTH-1:0] gen_strobe;
  logic [DATA_WIDTH-1:0]   gen_mask;
  logic                    gen_err;
  logic                    accept;
  logic                    hold_done;

  ram_strobe_gen #(
    .DATA_WIDTH   (DATA_WIDTH),
    .STROBE_WIDTH (STROBE_WIDTH)
  ) u_strobe_gen (
    .lane   (cmd_addr[LANE_WIDTH-1:0]),
    .bytes  (cmd_bytes),
    .strobe (gen_strobe),
    .mask   (gen_mask),
    .err    (gen_err)
  );

  always_comb begin
    accept     = cmd_valid && cmd_ready;
    hold_done  = (hold_cnt == LAST_CNT);
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = gen_err ? RESP : ACCESS;
      ACCESS:  if (hold_done) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Every output is a register loaded on the transition that changes it, so
  // the RAM sees a clean, glitch-free window and responses stay stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      ram_cs      <= 1'b0;
      ram_wr_enb  <= 1'b0;
      ram_addr    <= '0;
      ram_strobe  <= '0;
      ram_data_in <= '0;
      mask_q      <= '0;
      hold_cnt    <= '0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            if (gen_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              ram_cs      <= 1'b1;
              ram_wr_enb  <= cmd_write;
              ram_addr    <= cmd_addr;
              ram_strobe  <= gen_strobe;
              ram_data_in <= cmd_wdata;
              mask_q      <= gen_mask;
              hold_cnt    <= '0;
            end
          end
        end
        ACCESS: begin
          if (hold_done) begin
            // RAM registered its read data on the first cs edge, so it is
            // settled by the edge that closes the window.
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b0;
            rsp_rdata   <= ram_wr_enb ? '0 : (ram_data_out & mask_q);
            ram_cs      <= 1'b0;
            ram_wr_enb  <= 1'b0;
            ram_addr    <= '0;
            ram_strobe  <= '0;
            ram_data_in <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_WIDTH'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
module tb_ram_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [9:0]  cmd_addr;
  logic [63:0] cmd_wdata;
  logic [3:0]  cmd_bytes;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_cs;
  logic        ram_wr_enb;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_strobe;
  logic [63:0] ram_data_in;
  logic [63:0] ram_data_out = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_vld_cnt = 0;

  bit [63:0] ram_mem [1024];
  bit [63:0] ref_mem [1024];

  ram_initiator #(
    .ADDR_WIDTH   (10),
    .DATA_WIDTH   (64),
    .STROBE_WIDTH (8),
    .HOLD_CYCLES  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_bytes    (cmd_bytes),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_cs       (ram_cs),
    .ram_wr_enb   (ram_wr_enb),
    .ram_addr     (ram_addr),
    .ram_strobe   (ram_strobe),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_vld_cnt <= rsp_vld_cnt + 1;

  // Behavioural RAM_1K: byte-strobed write, registered read.
  always @(posedge clk) begin : ram_model
    logic [63:0] nw;
    if (ram_cs === 1'b1) begin
      if (ram_wr_enb === 1'b1) begin
        nw = ram_mem[ram_addr];
        for (int i = 0; i < 8; i++)
          if (ram_strobe[i]) nw[8*i +: 8] = ram_data_in[8*i +: 8];
        ram_mem[ram_addr] <= nw;
      end else begin
        ram_data_out <= ram_mem[ram_addr];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference model: command semantics from lane/byte-count arithmetic.
  task automatic model_cmd(input logic w, input logic [9:0] a, input logic [63:0] d,
                           input logic [3:0] b, output logic e, output logic [7:0] s,
                           output logic [63:0] rd);
    int lane;
    int nb;
    lane = int'(a) % 8;
    nb   = int'(b);
    e    = !(nb == 1 || nb == 2 || nb == 4 || nb == 8) || (lane + nb > 8);
    s    = '0;
    rd   = '0;
    if (!e) begin
      for (int i = 0; i < 8; i++)
        if (i >= lane && i < lane + nb) s[i] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (s[i]) begin
          if (w) ref_mem[a][8*i +: 8] = d[8*i +: 8];
          else   rd[8*i +: 8] = ref_mem[a][8*i +: 8];
        end
      end
    end
  endtask

  // Issue one command (entered at a negedge) and observe it to its response.
  task automatic run_cmd(input logic w, input logic [9:0] a, input logic [63:0] d,
                         input logic [3:0] b, input logic rdy,
                         output logic [63:0] rdata, output logic err, output int cs_cnt,
                         output logic [7:0] strb, output logic wr_seen, output int lat,
                         output int acc_cyc, output logic timeout);
    int   t;
    logic done;
    timeout = 1'b0; rdata = '0; err = 1'b0; cs_cnt = 0; strb = '0;
    wr_seen = 1'b0; lat = 0; acc_cyc = 0; done = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_bytes = b;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (cmd_ready !== 1'b1) begin
      timeout   = 1'b1;
      cmd_valid = 1'b0;
    end else begin
      rsp_ready = rdy;
      acc_cyc   = cyc + 1;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      t = 0;
      while (!done && t < 50) begin
        if (ram_cs === 1'b1) begin
          cs_cnt++;
          strb    = ram_strobe;
          wr_seen = ram_wr_enb;
        end
        if (rsp_valid === 1'b1) begin
          rdata = rsp_rdata;
          err   = rsp_err;
          done  = 1'b1;
        end else begin
          @(negedge clk);
          lat++;
          t++;
        end
      end
      if (!done) timeout = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, ram_cs, ram_wr_enb} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {cmd_ready, rsp_valid, rsp_err, ram_cs, ram_wr_enb});
    end
    checks++;
    if ({rsp_rdata, ram_addr, ram_strobe, ram_data_in} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h required all zero",
               rsp_rdata, ram_addr, ram_strobe, ram_data_in);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_basic();
    logic [63:0] rd, e_rd; logic er, e_err, wr, to; logic [7:0] sb, e_sb; int csn, lat, acc;
    model_cmd(1'b1, 10'd0, 64'h0000_0000_1234_5678, 4'd4, e_err, e_sb, e_rd);
    run_cmd(1'b1, 10'd0, 64'h0000_0000_1234_5678, 4'd4, 1'b1, rd, er, csn, sb, wr, lat, acc, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL wr0_timeout: got %b required 0", to); end
    checks++;
    if (sb !== 8'h0F) begin errors++; $display("FAIL wr0_strobe: got %h required 0f", sb); end
    checks++;
    if (csn != 2) begin errors++; $display("FAIL wr0_cs_cycles: got %0d required 2", csn); end
    checks++;
    if (wr !== 1'b1) begin errors++; $display("FAIL wr0_wr_enb: got %b required 1", wr); end
    checks++;
    if ({er, rd} !== {1'b0, 64'h0}) begin
      errors++;
      $display("FAIL wr0_rsp: got err %b data %h required err 0 data 0", er, rd);
    end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL wr0_latency: got %0d required 3", lat); end
  endtask

  task automatic test_write_read();
    logic [63:0] rd, e_rd; logic er, e_err, wr, to; logic [7:0] sb, e_sb; int csn, lat, acc;
    model_cmd(1'b1, 10'd76, 64'h78ac_d090_5678_9012, 4'd4, e_err, e_sb, e_rd);
    run_cmd(1'b1, 10'd76, 64'h78ac_d090_5678_9012, 4'd4, 1'b1, rd, er, csn, sb, wr, lat, acc, to);
    checks++;
    if (sb !== 8'hF0) begin errors++; $display("FAIL wr76_strobe: got %h required f0", sb); end
    model_cmd(1'b0, 10'd76, 64'h0, 4'd4, e_err, e_sb, e_rd);
    run_cmd(1'b0, 10'd76, 64'h0, 4'd4, 1'b1, rd, er, csn, sb, wr, lat, acc, to);
    checks++;
    if (sb !== 8'hF0) begin errors++; $display("FAIL rd76_strobe: got %h required f0", sb); end
    checks++;
    if (wr !== 1'b0) begin errors++; $display("FAIL rd76_wr_enb: got %b required 0", wr); end
    checks++;
    if (rd !== 64'h78ac_d090_0000_0000) begin
      errors++;
      $display("FAIL rd76_data: got %h required 78acd09000000000", rd);
    end
    checks++;
    if (er !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL rd76_rsp: got err %b lat %0d required err 0 lat 3", er, lat);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er, wr, to; logic [7:0] sb; int csn, lat, acc;
    run_cmd(1'b1, 10'd78, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 1'b1, rd, er, csn, sb, wr, lat, acc, to);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL err_overflow: got %b required 1", er); end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL err_overflow_latency: got %0d required 1", lat); end
    checks++;
    if (csn != 0) begin errors++; $display("FAIL err_overflow_cs: got %0d cycles required 0", csn); end
    checks++;
    if (rd !== 64'h0) begin errors++; $display("FAIL err_overflow_data: got %h required 0", rd); end
    run_cmd(1'b0, 10'd0, 64'h0, 4'd3, 1'b1, rd, er, csn, sb, wr, lat, acc, to);
    checks++;
    if ({er, csn != 0} !== 2'b10) begin
      errors++;
      $display("FAIL err_bytes3: got err %b cs %0d required err 1 cs 0", er, csn);
    end
  endtask

  task automatic test_hold();
    logic [63:0] rd, e_rd, saved; logic er, e_err, wr, to; logic [7:0] sb, e_sb; int csn, lat, acc;
    model_cmd(1'b1, 10'd136, 64'hDEAD_BEEF_0BAD_F00D, 4'd8, e_err, e_sb, e_rd);
    run_cmd(1'b1, 10'd136, 64'hDEAD_BEEF_0BAD_F00D, 4'd8, 1'b1, rd, er, csn, sb, wr, lat, acc, to);
    model_cmd(1'b0, 10'd136, 64'h0, 4'd8, e_err, e_sb, e_rd);
    run_cmd(1'b0, 10'd136, 64'h0, 4'd8, 1'b0, rd, er, csn, sb, wr, lat, acc, to);
    saved = rd;
    checks++;
    if (sb !== 8'hFF) begin errors++; $display("FAIL hold_strobe: got %h required ff", sb); end
    checks++;
    if (rd !== 64'hDEAD_BEEF_0BAD_F00D) begin
      errors++;
      $display("FAIL hold_data: got %h required deadbeef0badf00d", rd);
    end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, cmd_ready, ram_cs} !== 4'b1000 || rsp_rdata !== saved) begin
        errors++;
        $display("FAIL hold_stable_%0d: got vld/err/rdy/cs %b data %h required 1000 data %h",
                 k, {rsp_valid, rsp_err, cmd_ready, ram_cs}, rsp_rdata, saved);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release: got vld/rdy %b required 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, e_rd; logic er, e_err, wr, to; logic [7:0] sb, e_sb; int csn, lat;
    int acc [4];
    logic [9:0] addrs [4];
    logic [3:0] nbs [4];
    int c0;
    addrs = '{10'd0, 10'd76, 10'd136, 10'd77};
    nbs   = '{4'd4, 4'd4, 4'd8, 4'd1};
    c0 = rsp_vld_cnt;
    for (int i = 0; i < 4; i++) begin
      model_cmd(1'b0, addrs[i], 64'h0, nbs[i], e_err, e_sb, e_rd);
      run_cmd(1'b0, addrs[i], 64'h0, nbs[i], 1'b1, rd, er, csn, sb, wr, lat, acc[i], to);
      checks++;
      if (rd !== e_rd || er !== e_err || to !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rsp_%0d: got data %h err %b to %b required data %h err %b to 0",
                 i, rd, er, to, e_rd, e_err);
      end
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_pace_%0d: got %0d cycles required 4", i, acc[i] - acc[i-1]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_after: got vld/rdy %b required 01", {rsp_valid, cmd_ready});
    end
    checks++;
    if (rsp_vld_cnt - c0 != 4) begin
      errors++;
      $display("FAIL b2b_rsp_cycles: got %0d required 4", rsp_vld_cnt - c0);
    end
  endtask

  task automatic test_reset_mid_access();
    int t;
    int c0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd136; cmd_bytes = 4'd8; rsp_ready = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_cs !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_cs_before: got %b required 1", ram_cs);
    end
    c0 = rsp_vld_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, ram_cs, ram_wr_enb} !== 5'b0 ||
        {rsp_rdata, ram_addr, ram_strobe, ram_data_in} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got ctrl %b strobe %h addr %h required all zero",
               {cmd_ready, rsp_valid, rsp_err, ram_cs, ram_wr_enb}, ram_strobe, ram_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b required 1", cmd_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_vld_cnt != c0) begin
      errors++;
      $display("FAIL rstmid_no_rsp: got %0d responses required 0", rsp_vld_cnt - c0);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, e_rd, d; logic er, e_err, wr, to, w; logic [7:0] sb, e_sb;
    logic [9:0] a; logic [3:0] b; int csn, lat, acc, r;
    for (int n = 0; n < 40; n++) begin
      w = 1'(($urandom_range(0, 1)));
      a = 10'(200 + $urandom_range(0, 15));
      d = {$urandom, $urandom};
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    b = 4'd1;
        2, 3:    b = 4'd2;
        4, 5:    b = 4'd4;
        6, 7:    b = 4'd8;
        8:       b = 4'd3;
        default: b = 4'($urandom_range(0, 15));
      endcase
      model_cmd(w, a, d, b, e_err, e_sb, e_rd);
      run_cmd(w, a, d, b, 1'b1, rd, er, csn, sb, wr, lat, acc, to);
      checks++;
      if (to !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_timeout: got %b required 0", n, to);
      end
      checks++;
      if (er !== e_err) begin
        errors++;
        $display("FAIL rnd%0d_err: got %b required %b", n, er, e_err);
      end
      checks++;
      if (sb !== e_sb) begin
        errors++;
        $display("FAIL rnd%0d_strobe: got %h required %h", n, sb, e_sb);
      end
      checks++;
      if (csn != (e_err ? 0 : 2)) begin
        errors++;
        $display("FAIL rnd%0d_cs_cycles: got %0d required %0d", n, csn, e_err ? 0 : 2);
      end
      checks++;
      if (rd !== e_rd) begin
        errors++;
        $display("FAIL rnd%0d_data: got %h required %h", n, rd, e_rd);
      end
      checks++;
      if (lat != (e_err ? 1 : 3)) begin
        errors++;
        $display("FAIL rnd%0d_latency: got %0d required %0d", n, lat, e_err ? 1 : 3);
      end
      checks++;
      if (wr !== (e_err ? 1'b0 : w)) begin
        errors++;
        $display("FAIL rnd%0d_wr_enb: got %b required %b", n, wr, e_err ? 1'b0 : w);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_bytes = '0; rsp_ready = 1'b0;
  end

  initial begin
    #1;
    test_reset();
    test_write_basic();
    test_write_read();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_initiator.md
# ram_initiator

Hardware initiator for the team's byte-strobed single-port RAM (RAM_1K: cs, wr_enb, addr, strobe, data_in, data_out). It accepts read/write commands on a valid/ready port, converts byte count and address into a lane strobe, drives the RAM for a fixed hold window, and returns a response with masked read data. It sits between any command source (DMA, CPU bridge) and the RAM, replacing bench-style task sequencing with synthesizable control.

## Interface
- ADDR_WIDTH, 10, RAM word address width
- DATA_WIDTH, 64, data width; STROBE_WIDTH = DATA_WIDTH/8
- STROBE_WIDTH, 8, byte lanes
- HOLD_CYCLES, 2, cycles cs is held per access; minimum 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  address
- cmd_wdata  in  DATA_WIDTH  write data, lane-aligned
- cmd_bytes  in  4  byte count: 1, 2, 4 or 8
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data, unselected lanes zero; 0 for writes/errors
- rsp_err  out  1  command rejected, no RAM access made
- ram_cs, ram_wr_enb  out  1 each  RAM controls
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_strobe  out  STROBE_WIDTH  byte-lane enables
- ram_data_in  out  DATA_WIDTH  write data to RAM
- ram_data_out  in  DATA_WIDTH  read data from RAM (RAM registers it one edge after cs && !wr_enb)

## Operation
- Lane = cmd_addr mod STROBE_WIDTH; strobe = ((1<<cmd_bytes)-1) << lane.
- Error if cmd_bytes not in {1,2,4,8} or lane+cmd_bytes > STROBE_WIDTH; errored command skips RAM.
- FSM: IDLE -> (accept, legal) ACCESS; IDLE -> (accept, error) RESP; ACCESS -> (HOLD_CYCLES elapsed) RESP; RESP -> (rsp_ready) IDLE.
- IDLE: cmd_ready=1, all ram_* = 0.
- ACCESS: ram_cs=1, ram_wr_enb=cmd_write, ram_addr/strobe/data_in from latched command, stable for whole window; hold counter counts 0..HOLD_CYCLES-1.
- Read: ram_data_out sampled at the edge ending ACCESS, ANDed with lane mask into rsp_rdata.
- RESP: rsp_valid held with stable rsp_rdata/rsp_err until rsp_ready; cmd_ready=0.
- Single outstanding command; no pipelining.

## Timing
- All outputs registered. Reset values: cmd_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, ram_cs 0, ram_wr_enb 0, ram_addr 0, ram_strobe 0, ram_data_in 0; state IDLE.
- cmd_ready rises at first rising edge after rst deasserts.
- Accept at edge T: ram_cs high for cycles T+1..T+HOLD_CYCLES; rsp_valid high from T+HOLD_CYCLES+1.
- Error accept at T: rsp_valid, rsp_err high at T+1; ram_cs never asserts.
- rsp_ready already high when rsp_valid rises: response lasts one cycle, cmd_ready high next cycle; back-to-back command accepted that cycle.
- Write-to-read same address: read returns the new data.
- rst asserted mid-ACCESS: ram_* drop to 0 immediately; partial write may have landed; response discarded.

## Structure
- Package ram_if_pkg: state enum (IDLE, ACCESS, RESP), default width constants, lane-mask function.
- Sub-module ram_strobe_gen: combinational cmd_addr/cmd_bytes -> strobe, lane mask, error flag.

## Test plan
- Write addr 0, data 64'h0000_0000_1234_5678, bytes 4 -> ram_strobe 8'h0F, cs for 2 cycles, rsp_err 0, rsp_rdata 0.
- Write addr 76, 64'h78ac_d090_5678_9012, bytes 4, then read addr 76 bytes 4 -> strobe 8'hF0; rsp_rdata 64'h78ac_d090_0000_0000.
- Write addr 78, bytes 4 (lane 6 overflow) -> rsp_err 1 at T+1, ram_cs stays 0; cmd_bytes 3 -> rsp_err 1.
- Read addr 136 bytes 8 with rsp_ready low 5 cycles -> strobe 8'hFF, rsp_valid/rsp_rdata stable 5 cycles, cmd_ready 0 throughout.
- Assert rst in second ACCESS cycle -> all outputs zero same cycle, cmd_ready 1 one edge after release, no rsp_valid.
- rsp_ready tied high, 4 back-to-back reads -> each rsp_valid one cycle, one command per HOLD_CYCLES+2 cycles.
